// File: rtl/align_shifter_pipe_if.sv
// Stream bundle for the FP-add alignment shifter.
// master drives operations and consumes results; slave is the shifter.
interface align_shifter_pipe_if #(
  parameter int WIDTH   = 11,
  parameter int SHAMT_W = 8,
  parameter int TAG_W   = 4
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_mant;
  logic [SHAMT_W-1:0] in_shamt;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_mant;
  logic               out_guard;
  logic               out_round;
  logic               out_sticky;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output flush, in_valid, in_mant, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_mant, out_guard, out_round,
    input  out_sticky, out_tag
  );

  modport slave (
    input  flush, in_valid, in_mant, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_mant, out_guard, out_round,
    output out_sticky, out_tag
  );
endinterface

// File: rtl/align_shifter_pipe.sv
// Pipelined right-shift aligner with guard/round/sticky extraction.
// Barrel levels are spread evenly over STAGES elastic register stages.
module align_shifter_pipe #(
  parameter int WIDTH   = 11,
  parameter int SHAMT_W = 8,
  parameter int STAGES  = 2,
  parameter int TAG_W   = 4
) (
  input logic                clk,
  input logic                rst,
  align_shifter_pipe_if.slave io
);
  localparam int EW   = WIDTH + 2;
  localparam int LVL  = $clog2(EW);
  localparam int LAST = STAGES - 1;

  logic [EW-1:0]    e_q   [STAGES];
  logic [EW-1:0]    e_d   [STAGES];
  logic [EW-1:0]    src_e [STAGES];
  logic [LVL-1:0]   sh_q  [STAGES];
  logic [LVL-1:0]   sh_d  [STAGES];
  logic [LVL-1:0]   src_sh[STAGES];
  logic             st_q  [STAGES];
  logic             st_d  [STAGES];
  logic             src_st[STAGES];
  logic [TAG_W-1:0] tag_q [STAGES];
  logic [TAG_W-1:0] tag_d [STAGES];
  logic [TAG_W-1:0] src_tg[STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] ld;

  logic           full;
  logic           in_rdy;
  logic           acc;
  logic           sat;
  logic [EW-1:0]  e_t;
  logic [LVL-1:0] sh_t;
  logic           st_t;

  // A stage may load unless it and every stage after it is stalled.
  always_comb begin
    full = 1'b1;
    ld   = '0;
    for (int k = 0; k < STAGES; k++) begin
      full = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        full = full & v_q[j];
      end
      ld[k] = !(full && !io.out_ready);
    end
  end

  assign in_rdy      = !rst && !io.flush && ld[0];
  assign acc         = io.in_valid && in_rdy;
  assign io.in_ready = in_rdy;

  // Stage inputs: saturation folded in at entry, then the register chain.
  always_comb begin
    sat       = 32'(io.in_shamt) >= 32'(EW);
    src_e[0]  = sat ? '0 : {io.in_mant, 2'b00};
    src_sh[0] = sat ? '0 : io.in_shamt[LVL-1:0];
    src_st[0] = sat ? (|io.in_mant) : 1'b0;
    src_tg[0] = io.in_tag;
    for (int k = 1; k < STAGES; k++) begin
      src_e[k]  = e_q[k-1];
      src_sh[k] = sh_q[k-1];
      src_st[k] = st_q[k-1];
      src_tg[k] = tag_q[k-1];
    end
  end

  // Each stage applies its share of the 2**j shift levels.
  always_comb begin
    e_t  = '0;
    sh_t = '0;
    st_t = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      e_t  = src_e[k];
      sh_t = src_sh[k];
      st_t = src_st[k];
      for (int j = 0; j < LVL; j++) begin
        if ((j * STAGES) / LVL == k && sh_t[j]) begin
          st_t = st_t
               | (|(e_t & ((EW'(1) << (2**j)) - EW'(1))));
          e_t  = e_t >> (2**j);
        end
      end
      e_d[k]   = e_t;
      sh_d[k]  = sh_t;
      st_d[k]  = st_t;
      tag_d[k] = src_tg[k];
    end
  end

  // Valid bits move with their data; flush empties the pipe.
  always_comb begin
    v_d = v_q;
    if (ld[0]) v_d[0] = acc;
    for (int k = 1; k < STAGES; k++) begin
      if (ld[k]) v_d[k] = v_q[k-1];
    end
    if (io.flush) v_d = '0;
  end

  // Stage registers; data only moves when the stage loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        e_q[k]   <= '0;
        sh_q[k]  <= '0;
        st_q[k]  <= 1'b0;
        tag_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          e_q[k]   <= e_d[k];
          sh_q[k]  <= sh_d[k];
          st_q[k]  <= st_d[k];
          tag_q[k] <= tag_d[k];
        end
      end
    end
  end

  assign io.out_valid  = v_q[LAST];
  assign io.out_mant   = e_q[LAST][EW-1:2];
  assign io.out_guard  = e_q[LAST][1];
  assign io.out_round  = e_q[LAST][0];
  assign io.out_sticky = st_q[LAST];
  assign io.out_tag    = tag_q[LAST];
endmodule

// File: tb/tb_align_shifter_pipe.sv
// Scoreboard bench for align_shifter_pipe.
// Directed vectors; a monitor pops expected results on each output transfer.
module tb_align_shifter_pipe;
  localparam int W  = 11;
  localparam int SW = 8;
  localparam int ST = 2;
  localparam int TW = 4;

  typedef struct packed {
    logic [W-1:0]  mant;
    logic          g;
    logic          r;
    logic          s;
    logic [TW-1:0] tag;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  align_shifter_pipe_if #(.WIDTH(W), .SHAMT_W(SW), .TAG_W(TW)) bus();

  align_shifter_pipe #(
    .WIDTH(W), .SHAMT_W(SW), .STAGES(ST), .TAG_W(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  res_t sb[$];
  res_t cur;
  res_t prev;
  res_t exp_r;
  logic prev_stall = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   accepts = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [W-1:0] m, input logic [SW-1:0] sh,
                      input logic [TW-1:0] t, input logic [W-1:0] em,
                      input logic g, input logic r, input logic s);
    int n;
    res_t e;
    n = 0;
    e = '{mant: em, g: g, r: r, s: s, tag: t};
    bus.in_valid = 1'b1;
    bus.in_mant  = m;
    bus.in_shamt = sh;
    bus.in_tag   = t;
    #1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=%0d required=<20 tag=%0h", n, t);
    end else begin
      sb.push_back(e);
      accepts++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Monitor: compare on output transfers, check stall stability.
  always @(negedge clk) begin
    #3;
    cur = {bus.out_mant, bus.out_guard, bus.out_round,
           bus.out_sticky, bus.out_tag};
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && bus.out_valid) begin
        checks++;
        if (cur !== prev) begin
          errors++;
          $display("FAIL stall_hold actual=%h required=%h", cur, prev);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out actual=%h required=none", cur);
        end else begin
          exp_r = sb.pop_front();
          if (cur !== exp_r) begin
            errors++;
            $display("FAIL result actual=%h required=%h", cur, exp_r);
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev = cur;
      if (bus.flush) begin
        sb.delete();
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_shamt  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_outputs", 32'({bus.out_mant, bus.out_guard, bus.out_round,
                            bus.out_sticky, bus.out_tag}), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    // Basic latency.
    @(negedge clk);
    send(11'h7FF, 8'd0, 4'h3, 11'h7FF, 0, 0, 0);
    #1;
    chk("lat_cycle1", 32'(bus.out_valid), 0);
    @(negedge clk);
    #1;
    chk("lat_cycle2", 32'(bus.out_valid), 1);
    @(negedge clk);

    // Directed vectors, back to back.
    send(11'h40F, 8'd3,   4'h1, 11'h081, 1, 1, 1);
    send(11'h001, 8'd13,  4'h2, 11'h000, 0, 0, 1);
    send(11'h000, 8'd200, 4'h3, 11'h000, 0, 0, 0);
    send(11'h400, 8'd12,  4'h4, 11'h000, 0, 1, 0);
    send(11'h555, 8'd7,   4'h5, 11'h00A, 1, 0, 1);
    send(11'h7FF, 8'd12,  4'h6, 11'h000, 0, 1, 1);
    send(11'h7FF, 8'd16,  4'h7, 11'h000, 0, 0, 1);
    send(11'h7FF, 8'd255, 4'h8, 11'h000, 0, 0, 1);
    send(11'h7FF, 8'd13,  4'h9, 11'h000, 0, 0, 1);
    send(11'h123, 8'd0,   4'hA, 11'h123, 0, 0, 0);
    send(11'h7FF, 8'd11,  4'hB, 11'h000, 1, 1, 1);
    repeat (4) @(negedge clk);
    chk("drain_vectors", 32'(sb.size()), 0);

    // Backpressure: out_ready low for 5 cycles.
    bus.out_ready = 1'b0;
    base = accepts;
    fork
      begin
        send(11'h7FF, 8'd0, 4'h0, 11'h7FF, 0, 0, 0);
        send(11'h7FF, 8'd1, 4'h1, 11'h3FF, 1, 0, 0);
        send(11'h7FF, 8'd2, 4'h2, 11'h1FF, 1, 1, 0);
        send(11'h7FF, 8'd3, 4'h3, 11'h0FF, 1, 1, 1);
        send(11'h7FF, 8'd4, 4'h4, 11'h07F, 1, 1, 1);
        send(11'h7FF, 8'd5, 4'h5, 11'h03F, 1, 1, 1);
      end
      begin
        repeat (4) @(negedge clk);
        #1;
        chk("bp_in_ready_low", 32'(bus.in_ready), 0);
        chk("bp_accepts", 32'(accepts - base), 2);
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
          #2;
          chk("bp_no_gap", 32'(bus.out_valid), 1);
          @(negedge clk);
        end
      end
    join
    repeat (3) @(negedge clk);
    chk("drain_bp", 32'(sb.size()), 0);

    // Flush with two ops in flight and a simultaneous input.
    send(11'h40F, 8'd3, 4'hA, 11'h081, 1, 1, 1);
    send(11'h555, 8'd7, 4'hB, 11'h00A, 1, 0, 1);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_mant  = 11'h7FF;
    bus.in_shamt = 8'd0;
    bus.in_tag   = 4'hC;
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    send(11'h001, 8'd13, 4'hD, 11'h000, 0, 0, 1);
    #1;
    chk("flush_lat1", 32'(bus.out_valid), 0);
    @(negedge clk);
    #1;
    chk("flush_lat2", 32'(bus.out_valid), 1);
    repeat (3) @(negedge clk);
    chk("drain_flush", 32'(sb.size()), 0);

    // Reset mid-stream with a full, stalled pipe.
    bus.out_ready = 1'b0;
    send(11'h7FF, 8'd1, 4'h1, 11'h3FF, 1, 0, 0);
    send(11'h7FF, 8'd2, 4'h2, 11'h1FF, 1, 1, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_outputs", 32'({bus.out_mant, bus.out_guard, bus.out_round,
                                bus.out_sticky, bus.out_tag}), 0);
    chk("mid_rst_in_ready_back", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    send(11'h40F, 8'd3, 4'hE, 11'h081, 1, 1, 1);
    repeat (4) @(negedge clk);
    chk("final_drain", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
